dl_router: RTL and testbench

DL_ROUTER -- requirements
Module: dl_router

---
 rtl/dl_router.sv | 146 ++++++++++++++
 tb/tb_dl_router.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_router.sv
// HPS download router: steers the ioctl stream to ROM, game-select or DIP storage
// and holds the game core in reset while a ROM/MOD load is in progress.
module dl_router #(
   parameter int POST_HOLD = 255,
   parameter int MOD_COUNT = 18
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic                 ext_reset,
   input  logic                 ioctl_download,
   input  logic                 ioctl_wr,
   input  logic [24:0]          ioctl_addr,
   input  logic [7:0]           ioctl_dout,
   input  logic [7:0]           ioctl_index,
   output logic [15:0]          dn_addr,
   output logic [7:0]           dn_data,
   output logic                 dn_wr,
   output logic [7:0]           mod,
   output logic [MOD_COUNT-1:0] mod_onehot,
   output logic [63:0]          dip,
   output logic                 core_reset,
   output logic [16:0]          rom_bytes,
   output logic                 dl_err
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ROM  = 3'd1;
   localparam logic [2:0] MOD  = 3'd2;
   localparam logic [2:0] DIP  = 3'd3;
   localparam logic [2:0] HOLD = 3'd4;

   localparam int CW = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(POST_HOLD - 1);

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [2:0]    start_state;
   logic [CW-1:0] hold_cnt;
   logic          dl_prev;
   logic          dl_rise;
   logic          dl_fall;
   logic          rom_entry;
   logic          rom_accept;
   logic          rom_reject;
   logic          dip_accept;

   assign dl_rise = ioctl_download & ~dl_prev;
   assign dl_fall = ~ioctl_download & dl_prev;

   always_comb begin
      start_state = IDLE;
      case (ioctl_index)
         8'd0:    start_state = ROM;
         8'd1:    start_state = MOD;
         8'd254:  start_state = DIP;
         default: start_state = IDLE;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (dl_rise) next_state = start_state;
         ROM, MOD: if (dl_fall) next_state = HOLD;
         DIP:      if (dl_fall) next_state = IDLE;
         HOLD: begin
            if (dl_rise)
               next_state = start_state;
            else if (hold_cnt == HOLD_LAST)
               next_state = IDLE;
         end
         default:  next_state = IDLE;
      endcase
   end

   assign rom_entry  = (next_state == ROM) && (state != ROM);
   assign rom_accept = (state == ROM) && ioctl_wr && (ioctl_addr[24:16] == '0);
   assign rom_reject = (state == ROM) && ioctl_wr && (ioctl_addr[24:16] != '0);
   assign dip_accept = (state == DIP) && ioctl_wr && (ioctl_addr[24:3] == '0);

   // dl_prev resets high so a download already in flight at reset release
   // never looks like a fresh rising edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= HOLD;
         hold_cnt <= '0;
         dl_prev  <= 1'b1;
      end else begin
         state   <= next_state;
         dl_prev <= ioctl_download;
         if (state == HOLD && next_state == HOLD)
            hold_cnt <= hold_cnt + CW'(1);
         else
            hold_cnt <= '0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dn_wr     <= 1'b0;
         dn_addr   <= '0;
         dn_data   <= '0;
         rom_bytes <= '0;
         dl_err    <= 1'b0;
      end else begin
         dn_wr <= rom_accept;
         if (rom_accept) begin
            dn_addr <= ioctl_addr[15:0];
            dn_data <= ioctl_dout;
         end
         if (rom_entry) begin
            rom_bytes <= '0;
            dl_err    <= 1'b0;
         end else begin
            if (rom_accept && rom_bytes != 17'h10000)
               rom_bytes <= rom_bytes + 17'd1;
            if (rom_reject)
               dl_err <= 1'b1;
         end
      end
   end

   // Game select, its one-hot decode (one cycle behind mod) and DIP bytes.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mod        <= '0;
         mod_onehot <= MOD_COUNT'(1);
         dip        <= '1;
      end else begin
         if (state == MOD && ioctl_wr)
            mod <= ioctl_dout;
         for (int n = 0; n < MOD_COUNT; n++)
            mod_onehot[n] <= (mod == 8'(n));
         if (dip_accept)
            dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         core_reset <= 1'b1;
      else
         core_reset <= ext_reset || (state == ROM) || (state == MOD) || (state == HOLD);
   end

endmodule

// File: tb/tb_dl_router.sv
// Scoreboard bench for dl_router: randomized and directed downloads checked
// against a behavioural model of the load rules.
module tb_dl_router;

   localparam int POST_HOLD = 255;
   localparam int MOD_COUNT = 18;

   logic                 clk_sys = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 ext_reset = 1'b0;
   logic                 ioctl_download = 1'b0;
   logic                 ioctl_wr = 1'b0;
   logic [24:0]          ioctl_addr = '0;
   logic [7:0]           ioctl_dout = '0;
   logic [7:0]           ioctl_index = '0;
   logic [15:0]          dn_addr;
   logic [7:0]           dn_data;
   logic                 dn_wr;
   logic [7:0]           mod;
   logic [MOD_COUNT-1:0] mod_onehot;
   logic [63:0]          dip;
   logic                 core_reset;
   logic [16:0]          rom_bytes;
   logic                 dl_err;

   dl_router #(.POST_HOLD(POST_HOLD), .MOD_COUNT(MOD_COUNT)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ext_reset      (ext_reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .mod            (mod),
      .mod_onehot     (mod_onehot),
      .dip            (dip),
      .core_reset     (core_reset),
      .rom_bytes      (rom_bytes),
      .dl_err         (dl_err)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_t;

   wr_t         expq[$];
   wr_t         mon_e;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;

   // Reference model of what the current download should do
   bit          rom_active = 0;
   bit          mod_active = 0;
   bit          dip_active = 0;
   int          rom_cnt = 0;
   bit          rom_err = 0;
   logic [7:0]  mod_model = '0;
   logic [63:0] dip_model = '1;

   bit          watch_hi = 0, seen_hi = 0;
   bit          watch_lo = 0, seen_lo = 0;

   always @(posedge clk_sys) cyc++;

   function automatic logic [MOD_COUNT-1:0] onehotOf(input logic [7:0] m);
      logic [MOD_COUNT-1:0] r;
      r = '0;
      if (int'(m) < MOD_COUNT) r[m] = 1'b1;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic startDownload(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
      rom_active = (idx == 8'd0);
      mod_active = (idx == 8'd1);
      dip_active = (idx == 8'd254);
      if (rom_active) begin
         rom_cnt = 0;
         rom_err = 0;
      end
      ioctl_index = 8'($urandom);
   endtask

   task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
      int k;
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      if (rom_active) begin
         if (a[24:16] == 9'd0) begin
            expq.push_back('{a[15:0], d, cyc + 1});
            if (rom_cnt < 65536) rom_cnt++;
         end else begin
            rom_err = 1;
         end
      end
      if (mod_active) mod_model = d;
      if (dip_active && a < 25'd8) begin
         k = int'(a[2:0]);
         dip_model[k*8 +: 8] = d;
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic endDownload();
      ioctl_download = 1'b0;
      tick();
      rom_active = 0;
      mod_active = 0;
      dip_active = 0;
   endtask

   task automatic waitRelease(input int start, input string name);
      int guard = 0;
      int len;
      while (core_reset && guard < 2000) begin
         tick();
         guard++;
      end
      len = cyc - start;
      n_total++;
      if (!core_reset && len >= POST_HOLD && len <= POST_HOLD + 1) n_pass++;
      else $display("[TB] FAIL %s: core_reset=%0b after %0d cycles, expected release after %0d..%0d",
                    name, core_reset, len, POST_HOLD, POST_HOLD + 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_dn_wr"}, dn_wr, 1'b0);
      checkOutput({tag, "_dn_addr"}, dn_addr, 16'h0);
      checkOutput({tag, "_dn_data"}, dn_data, 8'h0);
      checkOutput({tag, "_mod"}, mod, 8'h0);
      checkOutput({tag, "_mod_onehot"}, mod_onehot, onehotOf(8'h0));
      checkOutput({tag, "_dip"}, dip, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput({tag, "_core_reset"}, core_reset, 1'b1);
      checkOutput({tag, "_rom_bytes"}, rom_bytes, 17'h0);
      checkOutput({tag, "_dl_err"}, dl_err, 1'b0);
   endtask

   // Monitor: every dn_wr pulse consumes one scoreboard entry
   always @(negedge clk_sys) begin
      if (watch_hi && core_reset) seen_hi = 1;
      if (watch_lo && !core_reset) seen_lo = 1;
      if (reset_n && dn_wr) begin
         if (expq.size() == 0) begin
            n_total++;
            $display("[TB] FAIL dn_wr_unexpected: got write addr %0h data %0h, expected no write", dn_addr, dn_data);
         end else begin
            mon_e = expq.pop_front();
            checkOutput("dn_addr", dn_addr, mon_e.addr);
            checkOutput("dn_data", dn_data, mon_e.data);
            checkOutput("dn_latency", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: got no end of test, expected $finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int rel;
      logic [24:0] a;

      repeat (3) tick();
      checkResetValues("reset");
      reset_n = 1'b1;
      rel = cyc;
      waitRelease(rel, "release_after_reset");

      // Basic ROM load
      startDownload(8'd0);
      for (int i = 0; i < 4; i++) applyStimulus(25'(i), 8'hA0 + 8'(i));
      endDownload();
      rel = cyc;
      checkOutput("rom_bytes_4", rom_bytes, 17'd4);
      checkOutput("core_reset_hold", core_reset, 1'b1);
      waitRelease(rel, "rom_hold_release");

      // Out-of-range write sets the error, next ROM load clears it
      startDownload(8'd0);
      applyStimulus(25'h10000, 8'h55);
      applyStimulus(25'h0, 8'h12);
      checkOutput("dl_err_set", dl_err, 1'b1);
      checkOutput("rom_bytes_oor", rom_bytes, 17'd1);
      endDownload();
      startDownload(8'd0);
      checkOutput("dl_err_clear", dl_err, 1'b0);
      checkOutput("rom_bytes_clear", rom_bytes, 17'd0);

      // Randomized ROM traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) a = {9'($urandom_range(1, 511)), 16'($urandom)};
         else a = {9'd0, 16'($urandom)};
         applyStimulus(a, 8'($urandom));
         if ($urandom_range(0, 2) == 0) tick();
      end
      endDownload();
      tick();
      checkOutput("rand_rom_bytes", rom_bytes, 17'(rom_cnt));
      checkOutput("rand_dl_err", dl_err, rom_err);

      // Game select
      startDownload(8'd1);
      applyStimulus(25'h0, 8'h05);
      applyStimulus(25'h3, 8'h11);
      tick();
      checkOutput("mod_11", mod, mod_model);
      checkOutput("onehot_11", mod_onehot, onehotOf(mod_model));
      applyStimulus(25'h7, 8'h20);
      tick();
      checkOutput("mod_20", mod, mod_model);
      checkOutput("onehot_20", mod_onehot, onehotOf(mod_model));
      endDownload();
      waitRelease(cyc, "mod_hold_release");

      // DIP load never touches core_reset
      watch_hi = 1;
      seen_hi  = 0;
      startDownload(8'd254);
      applyStimulus(25'h2, 8'h3C);
      applyStimulus(25'h9, 8'h00);
      endDownload();
      tick();
      tick();
      watch_hi = 0;
      checkOutput("dip_bytes", dip, dip_model);
      checkOutput("dip_core_reset", seen_hi, 1'b0);

      // Unknown index: whole download ignored
      startDownload(8'h07);
      applyStimulus(25'h0, 8'h99);
      endDownload();
      tick();
      checkOutput("unknown_core_reset", core_reset, 1'b0);
      checkOutput("unknown_mod", mod, mod_model);

      ext_reset = 1'b1;
      tick();
      tick();
      checkOutput("ext_reset_on", core_reset, 1'b1);
      ext_reset = 1'b0;
      tick();
      tick();
      checkOutput("ext_reset_off", core_reset, 1'b0);

      // New ROM load aborts HOLD part-way through its count
      startDownload(8'd0);
      applyStimulus(25'h1234, 8'h5A);
      endDownload();
      watch_lo = 1;
      seen_lo  = 0;
      repeat (100) tick();
      startDownload(8'd0);
      checkOutput("abort_rom_bytes", rom_bytes, 17'd0);
      applyStimulus(25'h0042, 8'h77);
      tick();
      checkOutput("abort_rom_write", rom_bytes, 17'd1);
      watch_lo = 0;
      checkOutput("abort_core_reset_low", seen_lo, 1'b0);

      // Reset in the middle of that ROM load
      #3;
      reset_n = 1'b0;
      #1;
      rom_active = 0;
      rom_cnt    = 0;
      mod_model  = '0;
      dip_model  = '1;
      checkResetValues("midreset");
      tick();
      reset_n = 1'b1;
      rel = cyc;
      for (int i = 0; i < 3; i++) applyStimulus(25'(i + 8), 8'($urandom));
      endDownload();
      checkOutput("midreset_rom_bytes", rom_bytes, 17'd0);
      waitRelease(rel, "midreset_release");

      checkOutput("scoreboard_drain", expq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
